// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-granular sharing of one uart_tx between NUM_REQ byte streams
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_FRAME = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_data_ready,
  input  logic                 tx_done,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT_DONE = 2'd2;
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, owner, sel, cand;
  logic [7:0] byte_cnt;
  logic last_r, tx_done_prev, done_edge;
  logic [7:0] req_byte [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
    assign req_byte[i] = req_data[8*i +: 8];
  end
  assign done_edge = tx_done & ~tx_done_prev;
  always_comb begin
    sel = rr_ptr;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      sel = req_valid[cand] ? cand : sel;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      req_ready <= '0;
      tx_data_ready <= 1'b0;
      tx_data <= '0;
      busy <= 1'b0;
      rr_ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      byte_cnt <= '0;
      last_r <= 1'b0;
      tx_done_prev <= 1'b0;
    end else begin
      tx_done_prev <= tx_done;
      req_ready <= '0;
      tx_data_ready <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant <= NUM_REQ'(1) << sel;
          owner <= sel;
          rr_ptr <= sel;
          byte_cnt <= '0;
          busy <= 1'b1;
          state <= SEND;
        end
        SEND: if (req_valid[owner]) begin
          tx_data <= req_byte[owner];
          tx_data_ready <= 1'b1;
          req_ready <= NUM_REQ'(1) << owner;
          last_r <= req_last[owner];
          byte_cnt <= byte_cnt + 8'd1;
          state <= WAIT_DONE;
        end else begin
          grant <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        WAIT_DONE: if (done_edge) begin
          if (last_r || byte_cnt == 8'(MAX_FRAME)) begin
            grant <= '0;
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and uart_tx model checked against a frame-level arbitration model
module tb_uart_tx_arbiter;
  localparam int NR = 2, MF = 4;
  typedef logic [7:0] bq_t [$];
  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0] req_valid = '0, req_last = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_ready, grant;
  logic [7:0] tx_data;
  logic tx_data_ready, busy;
  logic tx_done = 1'b0;
  int total = 0, bad = 0, viol = 0, ntx = 0, nrdy = 0, cd = 0, hold = 0, exp_rr = NR - 1;
  logic [NR-1:0] prev_grant = '0;
  logic [7:0] rq_data [NR][$];
  logic rq_last [NR][$];
  bq_t got_bytes, exp_bytes, got_grants, exp_grants;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_FRAME(MF)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
    .tx_done(tx_done), .busy(busy)
  );
  function automatic int first_diff(input bq_t a, input bq_t b);
    int n = a.size() < b.size() ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    return a.size() == b.size() ? -1 : n;
  endfunction
  function automatic bit all_idle();
    if (busy !== 1'b0 || cd != 0 || tx_done) return 1'b0;
    for (int i = 0; i < NR; i++) if (rq_data[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = rq_data[i].size() > 0;
      if (rq_data[i].size() > 0) begin
        req_data[8*i +: 8] = rq_data[i][0];
        req_last[i] = rq_last[i][0];
      end else begin
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask
  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq_data[r].push_back(d);
    rq_last[r].push_back(l);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (!$onehot0(grant) || !$onehot0(req_ready) || (req_ready & ~grant) != '0 ||
        (|req_ready) !== tx_data_ready || busy !== (grant != '0) ||
        (prev_grant != '0 && grant != '0 && grant != prev_grant)) viol++;
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NR; i++) if (grant[i]) got_grants.push_back(8'(i));
    prev_grant = grant;
    for (int i = 0; i < NR; i++)
      if (req_ready[i] === 1'b1 && rq_data[i].size() > 0) begin
        void'(rq_data[i].pop_front());
        void'(rq_last[i].pop_front());
        nrdy++;
      end
    if (tx_data_ready === 1'b1) begin
      got_bytes.push_back(tx_data);
      ntx++;
      if (cd != 0) viol++;
      tx_done = 1'b0;
      cd = $urandom_range(2, 12);
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        tx_done = 1'b1;
        hold = $urandom_range(1, 4);
      end
    end else if (tx_done) begin
      hold--;
      if (hold == 0) tx_done = 1'b0;
    end
    drive();
  endtask
  task automatic clear_logs();
    got_bytes.delete();
    exp_bytes.delete();
    got_grants.delete();
    exp_grants.delete();
    ntx = 0;
    nrdy = 0;
    viol = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
    end
    step();
    rst = 1'b0;
    for (int n = 0; n < 40 && (cd != 0 || tx_done); n++) step();
    exp_rr = NR - 1;
    clear_logs();
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!all_idle() && n < budget);
    if (!all_idle()) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want idle", busy, n);
    end
  endtask
  task automatic predict();
    int pos [NR];
    int sel, n;
    logic lst;
    pos = '{default: 0};
    while (1) begin
      sel = -1;
      for (int k = 1; k <= NR && sel < 0; k++)
        if (pos[(exp_rr + k) % NR] < rq_data[(exp_rr + k) % NR].size()) sel = (exp_rr + k) % NR;
      if (sel < 0) break;
      exp_grants.push_back(8'(sel));
      n = 0;
      do begin
        exp_bytes.push_back(rq_data[sel][pos[sel]]);
        lst = rq_last[sel][pos[sel]];
        pos[sel]++;
        n++;
      end while (!lst && n < MF && pos[sel] < rq_data[sel].size());
      exp_rr = sel;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    total += 5;
    if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
    if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_data_ready got=%b want=0", tx_data_ready); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
  endtask
  task automatic test_single_frame();
    do_reset();
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    drive();
    predict();
    total++;
    if (grant !== 2'b00) begin bad++; $display("FAIL single_pre_grant got=%b want=00", grant); end
    step();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL single_grant_latency got=%b want=01", grant); end
    step();
    total++;
    if (tx_data_ready !== 1'b1 || tx_data !== 8'h01) begin
      bad++;
      $display("FAIL single_first_start got tdr=%b data=%h want tdr=1 data=01", tx_data_ready, tx_data);
    end
    wait_idle(500);
    total += 5;
    if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL single_bytes got=%p want=%p", got_bytes, exp_bytes); end
    if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL single_grants got=%p want=%p", got_grants, exp_grants); end
    if (ntx !== 3) begin bad++; $display("FAIL single_tx_pulses got=%0d want=3", ntx); end
    if (nrdy !== 3) begin bad++; $display("FAIL single_ready_pulses got=%0d want=3", nrdy); end
    if (viol !== 0) begin bad++; $display("FAIL single_invariants got=%0d violations want=0", viol); end
  endtask
  task automatic test_contention();
    do_reset();
    push(0, 8'hAA, 1'b0);
    push(0, 8'hBB, 1'b1);
    push(0, 8'hDD, 1'b1);
    push(1, 8'hCC, 1'b1);
    drive();
    predict();
    wait_idle(800);
    total += 3;
    if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL contention_bytes got=%p want=%p", got_bytes, exp_bytes); end
    if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL contention_grants got=%p want=%p", got_grants, exp_grants); end
    if (viol !== 0) begin bad++; $display("FAIL contention_invariants got=%0d violations want=0", viol); end
  endtask
  task automatic test_late_request();
    int n = 0;
    do_reset();
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    drive();
    while (got_bytes.size() < 2 && n < 200) begin step(); n++; end
    if (got_bytes.size() < 2) begin total++; bad++; $display("FAIL late_wait got=%0d bytes want=2", got_bytes.size()); end
    push(1, 8'hEE, 1'b1);
    drive();
    wait_idle(800);
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    exp_bytes.push_back(8'h33);
    exp_bytes.push_back(8'hEE);
    exp_grants.push_back(8'd0);
    exp_grants.push_back(8'd1);
    exp_rr = 1;
    total += 3;
    if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL late_bytes got=%p want=%p", got_bytes, exp_bytes); end
    if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL late_grants got=%p want=%p", got_grants, exp_grants); end
    if (viol !== 0) begin bad++; $display("FAIL late_invariants got=%0d violations want=0", viol); end
  endtask
  task automatic test_max_frame();
    do_reset();
    for (int i = 0; i < 6; i++) push(0, 8'(i), i == 5);
    push(1, 8'h99, 1'b1);
    drive();
    predict();
    wait_idle(1000);
    total += 3;
    if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL maxframe_bytes got=%p want=%p", got_bytes, exp_bytes); end
    if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL maxframe_grants got=%p want=%p", got_grants, exp_grants); end
    if (ntx !== 7) begin bad++; $display("FAIL maxframe_tx_pulses got=%0d want=7", ntx); end
  endtask
  task automatic test_abandon();
    int n = 0;
    do_reset();
    push(0, 8'h5A, 1'b0);
    push(1, 8'h77, 1'b1);
    drive();
    predict();
    while ((got_bytes.size() < 1 || grant === 2'b01) && n < 200) begin step(); n++; end
    total += 2;
    if (grant !== 2'b00) begin bad++; $display("FAIL abandon_release got=%b want=00", grant); end
    if (ntx !== 1) begin bad++; $display("FAIL abandon_tx_pulses got=%0d want=1", ntx); end
    wait_idle(500);
    total += 3;
    if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL abandon_bytes got=%p want=%p", got_bytes, exp_bytes); end
    if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL abandon_grants got=%p want=%p", got_grants, exp_grants); end
    if (viol !== 0) begin bad++; $display("FAIL abandon_invariants got=%0d violations want=0", viol); end
  endtask
  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset();
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b1);
    drive();
    while (got_bytes.size() < 1 && n < 200) begin step(); n++; end
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
    end
    step();
    total += 5;
    if (grant !== '0) begin bad++; $display("FAIL midrst_grant got=%b want=0", grant); end
    if (req_ready !== '0) begin bad++; $display("FAIL midrst_req_ready got=%b want=0", req_ready); end
    if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL midrst_tx_data_ready got=%b want=0", tx_data_ready); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL midrst_tx_data got=%h want=00", tx_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    rst = 1'b0;
    for (int k = 0; k < 40 && (cd != 0 || tx_done); k++) step();
    clear_logs();
    exp_rr = NR - 1;
    push(0, 8'hA0, 1'b1);
    push(1, 8'hB0, 1'b1);
    drive();
    predict();
    wait_idle(500);
    total += 2;
    if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL midrst_grants got=%p want=%p", got_grants, exp_grants); end
    if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL midrst_bytes got=%p want=%p", got_bytes, exp_bytes); end
  endtask
  task automatic test_random();
    int nf, len;
    for (int r = 0; r < 8; r++) begin
      clear_logs();
      for (int q = 0; q < NR; q++) begin
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push(q, 8'($urandom), b == len - 1);
        end
      end
      drive();
      predict();
      wait_idle(3000);
      total += 4;
      if (first_diff(got_bytes, exp_bytes) >= 0) begin bad++; $display("FAIL random%0d_bytes got=%p want=%p", r, got_bytes, exp_bytes); end
      if (first_diff(got_grants, exp_grants) >= 0) begin bad++; $display("FAIL random%0d_grants got=%p want=%p", r, got_grants, exp_grants); end
      if (nrdy !== exp_bytes.size()) begin bad++; $display("FAIL random%0d_ready got=%0d want=%0d", r, nrdy, exp_bytes.size()); end
      if (viol !== 0) begin bad++; $display("FAIL random%0d_invariants got=%0d violations want=0", r, viol); end
    end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_contention();
    test_late_request();
    test_max_frame();
    test_abandon();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx transmitter between NUM_REQ byte-stream requesters, e.g. the command-response path and a future input-pin event reporter. Arbitration is round-robin at frame granularity: a granted requester keeps the transmitter until its last byte, until it abandons the frame, or until MAX_FRAME bytes have been sent. It sequences the uart_tx start/done handshake and acknowledges each consumed byte back to the owning requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_FRAME, 8, max bytes per grant before forced release (1..255)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte on its slice of req_data; held until req_ready[i]
req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i]
req_last  in  NUM_REQ  current byte of requester i ends its frame
req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i consumed; requester advances at next edge
grant  out  NUM_REQ  one-hot current owner; all zero when idle
tx_data  out  8  byte to uart_tx
tx_data_ready  out  1  one-cycle start pulse to uart_tx
tx_done  in  1  uart_tx completion; rising edge = byte finished (pulse or level both accepted)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; grant, req_ready, tx_data_ready, tx_data, busy all 0; rr pointer = NUM_REQ-1, so req 0 wins the first contest; byte_cnt = 0; tx_done edge register = 0. Reset overrides every other event, mid-frame included. The byte in flight in uart_tx is not recalled; its tx_done edge is ignored.
- All outputs registered. tx_done_prev sampled every cycle; done_edge = tx_done & ~tx_done_prev.
- FSM states: IDLE, SEND, WAIT_DONE.
- IDLE: if any req_valid, select the first set index searching from rr_ptr+1 mod NUM_REQ upward with wrap. Register grant = onehot(sel) and rr_ptr = sel, byte_cnt = 0, then go to SEND. Latency from req_valid sampled to grant high: 1 cycle.
- SEND: if req_valid[g]: tx_data <= req_data[g], tx_data_ready <= 1, req_ready[g] <= 1 (both for exactly one cycle), last_r <= req_last[g], byte_cnt += 1, then go to WAIT_DONE. If req_valid[g] is low: frame abandoned; grant <= 0, go to IDLE, no pulse.
- WAIT_DONE: hold until done_edge. Then, if last_r or byte_cnt == MAX_FRAME: grant <= 0, go to IDLE. Otherwise go to SEND.
- Per-byte overhead beyond uart_tx time: 2 cycles (SEND plus edge detection). Grant-to-first tx_data_ready: 1 cycle.
- The grant never changes while in SEND or WAIT_DONE. Other requesters' req_valid is ignored until IDLE.
- Forced release at MAX_FRAME: the requester keeps req_valid high and re-arbitrates as a normal contender. rr_ptr points at it, so any other pending requester goes first.
- req_last with byte_cnt == MAX_FRAME on the same byte: a single release; no special case.
- Simultaneous done_edge and rst: rst wins.
- A done_edge seen in IDLE or SEND is ignored.
- req_ready is never asserted for a non-granted index. At most one bit of req_ready or grant is set.

Test Plan:
1. Drive req0 with frame 01,02,03 (last on 03), bench uart_rx CLK_PER_BIT=16 -> rx gets 01 02 03 in order; grant=01 from 1 cycle after valid until after the third done edge; exactly 3 req_ready[0] and 3 tx_data_ready pulses.
2. After reset, req0 (AA,BB) and req1 (CC) both valid in the same cycle, then req0 (DD) re-requests -> byte order AA BB CC DD; grant sequence 01,10,01.
3. req1 raises valid (EE) during the 2nd byte of req0 frame 11,22,33 -> rx gets 11 22 33 EE; no grant[1] before req0's last done edge.
4. MAX_FRAME=4; req0 streams 6 bytes 00..05 with last only on 05, req1 pending (99) -> rx gets 00 01 02 03 99 04 05.
5. req0 drops req_valid in SEND after 1 byte -> grant 0 the next cycle, no further tx_data_ready; pending req1 (77) is then transmitted normally.
6. Assert rst for 1 cycle in WAIT_DONE of req1 frame -> next cycle all outputs 0, busy 0; then req0 and req1 both valid -> req0 granted first.
